// File: rtl/stim_seq_gen.sv
// rtl/stim_seq_gen.sv - stimulus pulse sequencer (a1 -> gap -> b1 -> c1 burst -> d1)
//
// Ports:
//   clk_top    single clock, all state changes on its rising edge
//   reset_n    asynchronous active-low reset
//   start      request one transaction, sampled only in IDLE
//   gap        idle cycles between a1 and b1, latched at start
//   burst_len  number of c1 cycles, latched at start
//   hold       freezes sequencing and forces the pulses low while high
//   inj_err    error-injection request, latched at start
//   a1..d1     registered stimulus pulses, at most one high per cycle
//   r1         count of completed transactions (wraps)
//   busy       high in every state except IDLE
//
// Optional feature: define STIM_SEQ_ERR_INJ_EN to make a transaction started
// with inj_err=1 skip the B state (no b1 pulse). Without it inj_err is ignored.
module stim_seq_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk_top,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       gap,
    input  logic [3:0]       burst_len,
    input  logic             hold,
    input  logic             inj_err,
    output logic             a1,
    output logic             b1,
    output logic             c1,
    output logic             d1,
    output logic [CNT_W-1:0] r1,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A    = 3'd1,
        S_GAP  = 3'd2,
        S_B    = 3'd3,
        S_C    = 3'd4,
        S_D    = 3'd5
    } state_t;

    // state holds the slot currently being presented on the outputs; cnt is
    // the number of further cycles left in GAP or C after the current one.
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] gap_l, gap_l_nx;
    logic [3:0] burst_l, burst_l_nx;
    logic       r1_inc;
    logic       skip_b;

`ifdef STIM_SEQ_ERR_INJ_EN
    logic err_l, err_l_nx;
    assign skip_b = err_l;
`else
    logic unused_inj_err;
    assign unused_inj_err = inj_err;
    assign skip_b         = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        gap_l_nx   = gap_l;
        burst_l_nx = burst_l;
        r1_inc     = 1'b0;
`ifdef STIM_SEQ_ERR_INJ_EN
        err_l_nx   = err_l;
`endif
        // hold freezes everything: state, counters and latched fields.
        if (!hold) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        gap_l_nx   = gap;
                        burst_l_nx = burst_len;
`ifdef STIM_SEQ_ERR_INJ_EN
                        err_l_nx   = inj_err;
`endif
                        state_nx   = S_A;
                    end
                end
                S_A, S_GAP: begin
                    if (state == S_A && gap_l != 4'd0) begin
                        state_nx = S_GAP;
                        cnt_nx   = gap_l - 4'd1;
                    end else if (state == S_GAP && cnt != 4'd0) begin
                        cnt_nx = cnt - 4'd1;
                    end else if (!skip_b) begin
                        state_nx = S_B;
                    end else if (burst_l != 4'd0) begin
                        state_nx = S_C;
                        cnt_nx   = burst_l - 4'd1;
                    end else begin
                        state_nx = S_D;
                    end
                end
                S_B: begin
                    if (burst_l != 4'd0) begin
                        state_nx = S_C;
                        cnt_nx   = burst_l - 4'd1;
                    end else begin
                        state_nx = S_D;
                    end
                end
                S_C: begin
                    if (cnt != 4'd0) begin
                        cnt_nx = cnt - 4'd1;
                    end else begin
                        state_nx = S_D;
                    end
                end
                S_D: begin
                    // start seen in this cycle is deliberately dropped
                    state_nx = S_IDLE;
                    r1_inc   = 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_top or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            gap_l   <= 4'd0;
            burst_l <= 4'd0;
`ifdef STIM_SEQ_ERR_INJ_EN
            err_l   <= 1'b0;
`endif
            a1      <= 1'b0;
            b1      <= 1'b0;
            c1      <= 1'b0;
            d1      <= 1'b0;
            busy    <= 1'b0;
            r1      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            gap_l   <= gap_l_nx;
            burst_l <= burst_l_nx;
`ifdef STIM_SEQ_ERR_INJ_EN
            err_l   <= err_l_nx;
`endif
            // Pulses are decoded from the next state so they line up with it;
            // a held cycle presents no pulse.
            a1      <= !hold && (state_nx == S_A);
            b1      <= !hold && (state_nx == S_B);
            c1      <= !hold && (state_nx == S_C);
            d1      <= !hold && (state_nx == S_D);
            busy    <= (state_nx != S_IDLE);
            if (r1_inc) begin
                r1 <= r1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stim_seq_gen.sv
// tb/tb_stim_seq_gen.sv - self-checking bench for stim_seq_gen
module tb_stim_seq_gen;

    localparam int CW = 4;

    logic          clk_top = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    gap = 4'd0;
    logic [3:0]    burst_len = 4'd0;
    logic          hold = 1'b0;
    logic          inj_err = 1'b0;
    logic          a1, b1, c1, d1, busy;
    logic [CW-1:0] r1;

    int checks = 0;
    int fails = 0;

    // Reference model: a transaction is a list of slot codes
    // (1=a1, 2=gap, 3=b1, 4=c1, 5=d1); cur is the slot on show, 0 is idle.
    int q[$];
    int cur = 0;
    bit held = 0;
    int m_r1 = 0;

    stim_seq_gen #(.CNT_W(CW)) dut (
        .clk_top  (clk_top),
        .reset_n  (reset_n),
        .start    (start),
        .gap      (gap),
        .burst_len(burst_len),
        .hold     (hold),
        .inj_err  (inj_err),
        .a1       (a1),
        .b1       (b1),
        .c1       (c1),
        .d1       (d1),
        .r1       (r1),
        .busy     (busy)
    );

    always #5 clk_top = ~clk_top;

    function automatic logic [3:0] code_pulses(input int c);
        case (c)
            1: return 4'b1000;
            3: return 4'b0100;
            4: return 4'b0010;
            5: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [4:0] model_vec();
        logic [3:0] p;
        p = held ? 4'b0000 : code_pulses(cur);
        return {p, cur != 0};
    endfunction

    function automatic bit skip_b_model(input bit e);
`ifdef STIM_SEQ_ERR_INJ_EN
        return e;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        cur  = 0;
        held = 0;
        m_r1 = 0;
    endtask

    task automatic model_edge();
        if (cur == 0) begin
            held = 0;
            if (start && !hold) begin
                q.delete();
                q.push_back(1);
                for (int i = 0; i < int'(gap); i++) q.push_back(2);
                if (!skip_b_model(inj_err)) q.push_back(3);
                for (int i = 0; i < int'(burst_len); i++) q.push_back(4);
                q.push_back(5);
                cur = q.pop_front();
            end
        end else if (hold) begin
            held = 1;
        end else begin
            held = 0;
            if (q.size() == 0) begin
                m_r1 = (m_r1 + 1) % (1 << CW);
                cur  = 0;
            end else begin
                cur = q.pop_front();
            end
        end
    endtask

    task automatic step();
        @(posedge clk_top);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; hold = 1'b0; inj_err = 1'b0; gap = 4'd0; burst_len = 4'd0;
        repeat (2) @(posedge clk_top);
        @(negedge clk_top);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1; hold = 1'b0; gap = 4'd3; burst_len = 4'd3;
        repeat (2) @(posedge clk_top);
        #1;
        checks++;
        if ({a1, b1, c1, d1, busy} !== 5'b0 || r1 !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got pulses/busy=%b r1=%0d, want 00000 r1=0",
                     {a1, b1, c1, d1, busy}, r1);
        end
        do_reset();
    endtask

    // gap=2 burst=3; gap/burst_len are scrambled after acceptance
    task automatic test_basic();
        int pat[8] = '{1, 2, 2, 3, 4, 4, 4, 5};
        do_reset();
        start = 1'b1; gap = 4'd2; burst_len = 4'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) begin
                start = 1'b0; gap = 4'd15; burst_len = 4'd15;
            end
            checks++;
            if (i < 8) begin
                if ({a1, b1, c1, d1, busy} !== {code_pulses(pat[i]), 1'b1} || r1 !== 4'd0) begin
                    fails++;
                    $display("FAIL basic_cycle%0d: got %b r1=%0d, want %b r1=0",
                             i, {a1, b1, c1, d1, busy}, r1, {code_pulses(pat[i]), 1'b1});
                end
            end else if ({a1, b1, c1, d1, busy} !== 5'b0 || r1 !== 4'd1) begin
                fails++;
                $display("FAIL basic_done: got %b r1=%0d, want 00000 r1=1",
                         {a1, b1, c1, d1, busy}, r1);
            end
            checks++;
            if ({a1, b1, c1, d1, busy} !== model_vec()) begin
                fails++;
                $display("FAIL basic_model%0d: got %b want %b", i, {a1, b1, c1, d1, busy}, model_vec());
            end
        end
    endtask

    task automatic test_min();
        int busy_cnt = 0;
        do_reset();
        start = 1'b1; gap = 4'd0; burst_len = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            start = 1'b0;
            if (busy) busy_cnt++;
            checks++;
            if ({a1, b1, c1, d1, busy} !== model_vec() || r1 !== CW'(m_r1)) begin
                fails++;
                $display("FAIL min_cycle%0d: got %b r1=%0d, want %b r1=%0d",
                         i, {a1, b1, c1, d1, busy}, r1, model_vec(), m_r1);
            end
        end
        checks++;
        if (busy_cnt != 3 || r1 !== 4'd1) begin
            fails++;
            $display("FAIL min_length: busy cycles %0d r1=%0d, want 3 r1=1", busy_cnt, r1);
        end
    endtask

    task automatic test_back_to_back();
        int a_cnt = 0;
        do_reset();
        start = 1'b1; gap = 4'd1; burst_len = 4'd1;
        for (int i = 0; i < 26; i++) begin
            step();
            if (i == 19) start = 1'b0;
            if (a1) a_cnt++;
            checks++;
            if ({a1, b1, c1, d1, busy} !== model_vec() || r1 !== CW'(m_r1)
                || $countones({a1, b1, c1, d1}) > 1) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got %b r1=%0d, want %b r1=%0d",
                         i, {a1, b1, c1, d1, busy}, r1, model_vec(), m_r1);
            end
        end
        checks++;
        if (a_cnt != 4 || r1 !== 4'd4) begin
            fails++;
            $display("FAIL b2b_total: transactions %0d r1=%0d, want 4 r1=4", a_cnt, r1);
        end
    endtask

    // hold over the slot of the second c1 of a burst of 3
    task automatic test_hold();
        int pat[9] = '{1, 3, 4, 0, 0, 4, 4, 5, 0};
        do_reset();
        start = 1'b1; gap = 4'd0; burst_len = 4'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            start = 1'b0;
            hold  = (i == 2 || i == 3);
            checks++;
            if ({a1, b1, c1, d1} !== code_pulses(pat[i]) || {a1, b1, c1, d1, busy} !== model_vec()) begin
                fails++;
                $display("FAIL hold_cycle%0d: got %b, want pulses %b model %b",
                         i, {a1, b1, c1, d1, busy}, code_pulses(pat[i]), model_vec());
            end
        end
        checks++;
        if (r1 !== 4'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_done: r1=%0d busy=%b, want r1=1 busy=0", r1, busy);
        end
        // hold in IDLE blocks start
        hold = 1'b1; start = 1'b1;
        step();
        hold = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || a1 !== 1'b0) begin
            fails++;
            $display("FAIL hold_idle: busy=%b a1=%b, want 0 0", busy, a1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start = 1'b1; gap = 4'd5; burst_len = 4'd2;
        step();
        start = 1'b0;
        step();
        step();
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({a1, b1, c1, d1, busy} !== 5'b0 || r1 !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid: got %b r1=%0d, want 00000 r1=0", {a1, b1, c1, d1, busy}, r1);
        end
        @(negedge clk_top);
        start = 1'b1; gap = 4'd0; burst_len = 4'd0;
        reset_n = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (a1 !== 1'b1 || {a1, b1, c1, d1, busy} !== model_vec()) begin
            fails++;
            $display("FAIL reset_restart: got %b, want %b", {a1, b1, c1, d1, busy}, model_vec());
        end
        repeat (4) step();
    endtask

    task automatic test_err_inj();
`ifdef STIM_SEQ_ERR_INJ_EN
        int pat[5] = '{1, 2, 4, 5, 0};
`else
        int pat[5] = '{1, 2, 3, 4, 5};
`endif
        int b_cnt = 0;
        do_reset();
        start = 1'b1; gap = 4'd1; burst_len = 4'd1; inj_err = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0; inj_err = 1'b0;
            if (b1) b_cnt++;
            checks++;
            if (i < 5 && {a1, b1, c1, d1} !== code_pulses(pat[i])) begin
                fails++;
                $display("FAIL errinj_cycle%0d: got %b, want %b", i, {a1, b1, c1, d1}, code_pulses(pat[i]));
            end
        end
        checks++;
        if (r1 !== 4'd1) begin
            fails++;
            $display("FAIL errinj_count: r1=%0d, want 1", r1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 1) == 1);
            hold      = ($urandom_range(0, 4) == 0);
            inj_err   = ($urandom_range(0, 3) == 0);
            gap       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            burst_len = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            step();
            checks++;
            if ({a1, b1, c1, d1, busy} !== model_vec() || r1 !== CW'(m_r1)
                || $countones({a1, b1, c1, d1}) > 1) begin
                fails++;
                $display("FAIL random_cycle%0d: got %b r1=%0d, want %b r1=%0d",
                         i, {a1, b1, c1, d1, busy}, r1, model_vec(), m_r1);
            end
        end
        hold = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_err_inj();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stim_seq_gen.md
STIM_SEQ_GEN -- requirements
Module: stim_seq_gen

Interface
REQ-001 Parameter: CNT_W, default 32, width of the transaction counter r1.
REQ-002 clk_top  input  1  single clock; all state changes on posedge clk_top.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request one transaction; sampled only in IDLE.
REQ-005 gap  input  4  idle cycles between a1 and b1 (0..15).
REQ-006 burst_len  input  4  number of c1-high cycles (0..15).
REQ-007 hold  input  1  stall; freezes sequencing while high.
REQ-008 inj_err  input  1  error-injection request, sampled with start (see Configuration).
REQ-009 a1, b1, c1, d1  output  1 each  stimulus pulses driving the downstream DUT stage.
REQ-010 r1  output  CNT_W  count of completed transactions.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Block SHALL implement FSM states IDLE, A, GAP, B, C, D; all outputs registered.
REQ-013 IDLE: start=1 at edge t SHALL latch gap, burst_len and inj_err and enter A, so a1=1 in cycle t+1.
REQ-014 A: a1=1 for exactly one cycle; next state GAP if latched gap>0, else B.
REQ-015 GAP: all pulses low for exactly latched-gap cycles, counted by a down-counter, then B.
REQ-016 B: b1=1 for exactly one cycle; next state C if latched burst_len>0, else D.
REQ-017 C: c1=1 for exactly latched-burst_len consecutive cycles, then D.
REQ-018 D: d1=1 for one cycle; r1 SHALL increment by 1 on exit from D; next state IDLE.
REQ-019 At most one of a1, b1, c1, d1 SHALL be high in any cycle.
REQ-020 start while busy=1 SHALL be ignored and not queued; start in the D-exit cycle is also ignored.
REQ-021 Input changes to gap or burst_len during a transaction SHALL have no effect.
REQ-022 hold=1 SHALL freeze state and counters and force a1..d1 low for that cycle; on release, the interrupted pulse or count resumes with its remaining length.
REQ-023 hold=1 in IDLE SHALL block acceptance of start.
REQ-024 r1 SHALL wrap from 2^CNT_W-1 to 0 without error.
REQ-025 Minimum transaction (gap=0, burst_len=0) SHALL take 3 cycles: a1, b1, d1.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE, counters and latched fields 0, a1..d1=0, busy=0, r1=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no r1 increment; after release, the block SHALL accept start on the first posedge.

Configuration
REQ-028 Macro STIM_SEQ_ERR_INJ_EN: when defined, a transaction started with inj_err=1 SHALL skip B (A/GAP go directly to C or D), omitting b1 to provoke a downstream assertion failure, and r1 still increments.
REQ-029 Without STIM_SEQ_ERR_INJ_EN, inj_err SHALL be ignored, and the port remains present.

Verification
REQ-030 Reset, start at cycle 2, gap=2, burst_len=3 -> a1 cycle 3, low cycles 4-5, b1 cycle 6, c1 cycles 7-9, d1 cycle 10, r1=1 at cycle 11.
REQ-031 gap=0, burst_len=0 -> a1, b1, d1 on three consecutive cycles; busy high for 3 cycles.
REQ-032 start pulsed every cycle for 20 cycles with gap=1, burst_len=1 -> four transactions of 5 cycles each, then r1=4; no overlap; at most one pulse high per cycle.
REQ-033 hold=1 for 2 cycles during second c1 of burst_len=3 -> c1 low 2 cycles, then 2 more c1 cycles; total transaction 2 cycles longer.
REQ-034 reset_n low during GAP -> all outputs 0 immediately, r1 unchanged from pre-transaction value (0), next start works normally.
REQ-035 With STIM_SEQ_ERR_INJ_EN, inj_err=1, gap=1, burst_len=1 -> a1, one low cycle, c1, d1, and no b1; without the macro -> b1 present.
